// File: rtl/btn_color_sel_pkg.sv
// rtl/btn_color_sel_pkg.sv - shared colour constants and defaults for the button front end
package btn_color_sel_pkg;

    localparam int N_BTN_DEF      = 3;
    localparam int DEB_CYCLES_DEF = 1000;

    localparam logic [2:0] COLOR_RED   = 3'b100;
    localparam logic [2:0] COLOR_GREEN = 3'b010;
    localparam logic [2:0] COLOR_BLUE  = 3'b001;

endpackage

// File: rtl/btn_color_sel_debouncer.sv
// rtl/btn_color_sel_debouncer.sv - single-button synchroniser, debounce counter and press strobe
module btn_debouncer
    import btn_color_sel_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_deb,
    output logic o_press
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic             ff1_q, ff1_d;
    logic             ff2_q, ff2_d;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    always_comb begin
        ff1_d  = i_raw;
        ff2_d  = ff1_q;
        deb_d  = deb_q;
        cnt_d  = '0;
        accept = 1'b0;
        // Any cycle where the synchronised level matches the debounced one restarts the count.
        if (ff2_q != deb_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                deb_d  = ff2_q;
                accept = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
            deb_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            ff1_q <= ff1_d;
            ff2_q <= ff2_d;
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    // Combinational so the top can register the pulse on the same edge that raises deb_q.
    assign o_press = accept & ff2_q;
    assign o_deb   = deb_q;

endmodule

// File: rtl/btn_color_sel.sv
// rtl/btn_color_sel.sv - debounced, priority-resolved one-hot colour select for the LED bank
module btn_color_sel
    import btn_color_sel_pkg::*;
#(
    parameter int N_BTN      = N_BTN_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic [N_BTN-1:0] i_btn_raw,
    output logic [N_BTN-1:0] o_btn,
    output logic [N_BTN-1:0] o_sel,
    output logic [N_BTN-1:0] o_deb
);

    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] deb;
    logic [N_BTN-1:0] btn_q, btn_d;
    logic [N_BTN-1:0] sel_q, sel_d;

    for (genvar b = 0; b < N_BTN; b++) begin : g_btn
        btn_debouncer #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk    (clk),
            .i_reset(i_reset),
            .i_raw  (i_btn_raw[b]),
            .o_deb  (deb[b]),
            .o_press(press[b])
        );
    end

    always_comb begin
        btn_d = '0;
        // Later iterations overwrite earlier ones, so the highest pressed index wins.
        for (int i = 0; i < N_BTN; i++) begin
            if (press[i]) begin
                btn_d    = '0;
                btn_d[i] = 1'b1;
            end
        end
        sel_d = (btn_d != '0) ? btn_d : sel_q;
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            btn_q <= '0;
            sel_q <= '0;
        end else begin
            btn_q <= btn_d;
            sel_q <= sel_d;
        end
    end

    assign o_btn = btn_q;
    assign o_sel = sel_q;
    assign o_deb = deb;

endmodule

// File: tb/tb_btn_color_sel.sv
// tb/tb_btn_color_sel.sv - directed and randomised bench for btn_color_sel with a reference model
module tb_btn_color_sel;
    import btn_color_sel_pkg::*;

    localparam int N = 3;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         i_reset;
    logic [N-1:0] i_btn_raw;
    logic [N-1:0] o_btn, o_sel, o_deb;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: synchroniser as a two-stage delay, debounce as "last D samples all differ".
    logic [N-1:0] m_p1, m_p2, m_d, m_btn, m_sel;
    bit           hist [N][$];

    btn_color_sel #(
        .N_BTN     (N),
        .DEB_CYCLES(D)
    ) dut (
        .clk      (clk),
        .i_reset  (i_reset),
        .i_btn_raw(i_btn_raw),
        .o_btn    (o_btn),
        .o_sel    (o_sel),
        .o_deb    (o_deb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [N-1:0] raw, input logic rst);
        logic [N-1:0] press;
        bit           all_diff;
        press = '0;
        if (rst) begin
            m_p1 = '0; m_p2 = '0; m_d = '0; m_btn = '0; m_sel = '0;
            for (int b = 0; b < N; b++) hist[b].delete();
        end else begin
            for (int b = 0; b < N; b++) begin
                hist[b].push_back(m_p2[b]);
                if (hist[b].size() > D) void'(hist[b].pop_front());
                all_diff = (hist[b].size() == D);
                foreach (hist[b][k]) if (hist[b][k] == m_d[b]) all_diff = 0;
                if (all_diff) begin
                    m_d[b] = m_p2[b];
                    if (m_p2[b]) press[b] = 1'b1;
                end
            end
            m_p2 = m_p1;
            m_p1 = raw;
            if (press[2])      m_btn = COLOR_RED;
            else if (press[1]) m_btn = COLOR_GREEN;
            else if (press[0]) m_btn = COLOR_BLUE;
            else               m_btn = '0;
            if (m_btn != '0) m_sel = m_btn;
        end
    endtask

    task automatic step(input logic [N-1:0] raw, input logic rst);
        i_btn_raw = raw;
        i_reset   = rst;
        @(posedge clk);
        model_edge(raw, rst);
        #1;
        check("o_btn", 32'(o_btn), 32'(m_btn));
        check("o_sel", 32'(o_sel), 32'(m_sel));
        check("o_deb", 32'(o_deb), 32'(m_d));
    endtask

    task automatic hold(input logic [N-1:0] raw, input int n,
                        output int first, output logic [N-1:0] val, output int npulse);
        first = -1; val = '0; npulse = 0;
        for (int i = 1; i <= n; i++) begin
            step(raw, 1'b0);
            if (o_btn != '0) begin
                npulse++;
                if (first < 0) begin
                    first = i;
                    val   = o_btn;
                end
            end
        end
    endtask

    initial begin
        int           first, np, tot;
        logic [N-1:0] val;
        logic [N-1:0] r;
        i_reset   = 1'b1;
        i_btn_raw = '0;

        // Reset with all buttons held, then release.
        step(3'b111, 1'b1);
        step(3'b111, 1'b1);
        check("rst_btn", 32'(o_btn), 32'h0);
        hold(3'b111, 14, first, val, np);
        check("rst_first", 32'(first), 32'd6);
        check("rst_val", 32'(val), 32'(COLOR_RED));
        check("rst_np", 32'(np), 32'd1);
        check("rst_deb", 32'(o_deb), 32'b111);
        hold(3'b000, 10, first, val, np);
        check("rst_rel_np", 32'(np), 32'd0);

        // Clean green press and release.
        hold(3'b010, 10, first, val, np);
        check("grn_first", 32'(first), 32'd6);
        check("grn_val", 32'(val), 32'(COLOR_GREEN));
        check("grn_np", 32'(np), 32'd1);
        hold(3'b000, 10, first, val, np);
        check("grn_rel_np", 32'(np), 32'd0);
        check("grn_sel", 32'(o_sel), 32'(COLOR_GREEN));
        check("grn_deb", 32'(o_deb), 32'b000);

        // Bounce on blue, then stable.
        tot = 0;
        for (int k = 0; k < 2; k++) begin
            hold(3'b001, 2, first, val, np); tot += np;
            hold(3'b000, 2, first, val, np); tot += np;
        end
        check("bnc_np", 32'(tot), 32'd0);
        hold(3'b001, 10, first, val, np);
        check("bnc_first", 32'(first), 32'd6);
        check("bnc_val", 32'(val), 32'(COLOR_BLUE));
        hold(3'b000, 10, first, val, np);

        // Short glitch on green is rejected.
        hold(3'b010, 3, first, val, tot);
        hold(3'b000, 8, first, val, np);
        check("gl_np", 32'(np + tot), 32'd0);
        check("gl_deb", 32'(o_deb), 32'b000);
        check("gl_sel", 32'(o_sel), 32'(COLOR_BLUE));

        // Simultaneous green+blue: green wins, blue is dropped.
        hold(3'b011, 10, first, val, np);
        check("sim_val", 32'(val), 32'(COLOR_GREEN));
        check("sim_np", 32'(np), 32'd1);
        check("sim_deb", 32'(o_deb), 32'b011);
        hold(3'b001, 10, first, val, np);
        check("sim_rel_np", 32'(np), 32'd0);
        hold(3'b000, 10, first, val, np);

        // Reset mid-press on red.
        hold(3'b100, 3, first, val, np);
        check("mid_np", 32'(np), 32'd0);
        step(3'b100, 1'b1);
        hold(3'b100, 10, first, val, np);
        check("mid_first", 32'(first), 32'd6);
        check("mid_val", 32'(val), 32'(COLOR_RED));
        hold(3'b000, 10, first, val, np);

        // Randomised segments against the model.
        for (int s = 0; s < 400; s++) begin
            r = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) step(r, 1'b1);
            else hold(r, $urandom_range(1, 8), first, val, np);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
